tpum_xbox_loader: RTL and testbench



---
 rtl/tpum_xbox_loader.sv | 160 ++++++++++++++++
 tb/tb_tpum_xbox_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tpum_xbox_loader.sv
// XBOX transfer sequencer: loads R1/R2 operand rows and stores the RA result row
// through a fixed-latency XBOX memory port. All outputs are registered.
module tpum_xbox_loader #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_load,
  input  logic              cmd_store,
  input  logic [31:0]       base_pt_a,
  input  logic [31:0]       base_pt_b,
  input  logic [31:0]       base_pt_c,
  input  logic [DATA_W-1:0] ra_vec,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] r1_vec,
  output logic [DATA_W-1:0] r2_vec,
  output logic              xbox_rd,
  output logic              xbox_wr,
  output logic [ADDR_W-1:0] xbox_addr,
  output logic [DATA_W-1:0] xbox_wdata,
  input  logic [DATA_W-1:0] xbox_rdata
);

  typedef enum logic [2:0] {
    StIdle, StRdA, StWaitA, StRdB, StWaitB, StWrC, StDone
  } state_e;

  localparam logic [3:0] LatCnt = 4'(RD_LAT);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   b_q, b_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   r1_q, r1_d, r2_q, r2_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                rd_q, rd_d, wr_q, wr_d;

  logic a_oor, b_oor, c_oor;

  assign a_oor = |(base_pt_a >> ADDR_W);
  assign b_oor = |(base_pt_b >> ADDR_W);
  assign c_oor = |(base_pt_c >> ADDR_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Load wins over a simultaneous store; the dropped store is flagged.
        if (cmd_load) begin
          if (a_oor || b_oor) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            state_d = StRdA;
            addr_d  = base_pt_a[ADDR_W-1:0];
            b_d     = base_pt_b[ADDR_W-1:0];
            err_d   = cmd_store;
          end
        end else if (cmd_store) begin
          if (c_oor) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            state_d = StWrC;
            addr_d  = base_pt_c[ADDR_W-1:0];
            wdata_d = ra_vec;
          end
        end
      end
      StRdA: begin
        state_d = StWaitA;
        cnt_d   = LatCnt;
      end
      StWaitA: begin
        if (cnt_q == 4'd1) begin
          r1_d    = xbox_rdata;
          state_d = StRdB;
          addr_d  = b_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRdB: begin
        state_d = StWaitB;
        cnt_d   = LatCnt;
      end
      StWaitB: begin
        if (cnt_q == 4'd1) begin
          r2_d    = xbox_rdata;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrC:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Strobes and status are decoded from the next state so they register in step with it.
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    rd_d   = (state_d == StRdA) || (state_d == StRdB);
    wr_d   = (state_d == StWrC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      b_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign r1_vec     = r1_q;
  assign r2_vec     = r2_q;
  assign xbox_rd    = rd_q;
  assign xbox_wr    = wr_q;
  assign xbox_addr  = addr_q;
  assign xbox_wdata = wdata_q;

endmodule

// File: tb/tb_tpum_xbox_loader.sv
// Directed bench for tpum_xbox_loader with a 2-cycle XBOX read model returning {32{addr}}.
module tb_tpum_xbox_loader;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 1024;
  localparam int unsigned RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_load, cmd_store;
  logic [31:0]       base_pt_a, base_pt_b, base_pt_c;
  logic [DATA_W-1:0] ra_vec;
  logic              busy, done, err, xbox_rd, xbox_wr;
  logic [DATA_W-1:0] r1_vec, r2_vec, xbox_wdata, xbox_rdata;
  logic [ADDR_W-1:0] xbox_addr;

  int n_vec = 0;
  int n_err = 0;

  tpum_xbox_loader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_load  (cmd_load),
    .cmd_store (cmd_store),
    .base_pt_a (base_pt_a),
    .base_pt_b (base_pt_b),
    .base_pt_c (base_pt_c),
    .ra_vec    (ra_vec),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .r1_vec    (r1_vec),
    .r2_vec    (r2_vec),
    .xbox_rd   (xbox_rd),
    .xbox_wr   (xbox_wr),
    .xbox_addr (xbox_addr),
    .xbox_wdata(xbox_wdata),
    .xbox_rdata(xbox_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: data valid exactly RD_LAT cycles after the strobe, garbage otherwise.
  logic [DATA_W-1:0] p1, p2;
  always @(posedge clk) begin
    p1 <= xbox_rd ? {32{{(32 - ADDR_W){1'b0}}, xbox_addr}} : {32{32'hDEADBEEF}};
    p2 <= p1;
  end
  assign xbox_rdata = p2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [ADDR_W-1:0] obs,
                      input logic [ADDR_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DATA_W-1:0] obs,
                      input logic [DATA_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got low128 %0h expected low128 %0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic ctl(input string tag, input logic rd, input logic wr, input logic bsy,
                     input logic dn, input logic er);
    chk1({tag, ".rd"}, xbox_rd, rd);
    chk1({tag, ".wr"}, xbox_wr, wr);
    chk1({tag, ".busy"}, busy, bsy);
    chk1({tag, ".done"}, done, dn);
    chk1({tag, ".err"}, err, er);
  endtask

  task automatic rst_chk(input string tag);
    ctl(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chka({tag, ".addr"}, xbox_addr, '0);
    chkw({tag, ".wdata"}, xbox_wdata, '0);
    chkw({tag, ".r1"}, r1_vec, '0);
    chkw({tag, ".r2"}, r2_vec, '0);
  endtask

  logic [DATA_W-1:0] ra_exp;
  int done_cnt;

  initial begin
    rst_n = 1'b0;
    cmd_load = 1'b0;
    cmd_store = 1'b0;
    base_pt_a = '0;
    base_pt_b = '0;
    base_pt_c = '0;
    ra_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_chk("reset");
    rst_n = 1'b1;
    tick();

    // Basic load: strobes at T1/T4, done at T7.
    base_pt_a = 32'h10;
    base_pt_b = 32'h20;
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      ctl("load", (t == 1) || (t == 4), 1'b0, t <= 7, t == 7, 1'b0);
      if (t == 1) chka("load.addr_a", xbox_addr, 14'h10);
      if (t == 4) chka("load.addr_b", xbox_addr, 14'h20);
      if (t == 3) chkw("load.r1_early", r1_vec, '0);
      if (t == 4) chkw("load.r1", r1_vec, {32{32'h10}});
      if (t == 6) chkw("load.r2_early", r2_vec, '0);
      if (t == 7) chkw("load.r2", r2_vec, {32{32'h20}});
      tick();
    end

    // Store: word k = k, ra_vec cleared after acceptance must not leak through.
    for (int k = 0; k < 32; k++) ra_vec[32*k +: 32] = k;
    ra_exp = ra_vec;
    base_pt_c = 32'h3FFF;
    cmd_store = 1'b1;
    tick();
    cmd_store = 1'b0;
    ra_vec = '0;
    for (int t = 1; t <= 3; t++) begin
      ctl("store", 1'b0, t == 1, t <= 2, t == 2, 1'b0);
      if (t == 1) chka("store.addr", xbox_addr, 14'h3FFF);
      if (t == 1) chkw("store.wdata", xbox_wdata, ra_exp);
      if (t == 3) chkw("store.wdata_hold", xbox_wdata, ra_exp);
      tick();
    end

    // Out-of-range A: immediate done+err, no access, operands untouched.
    base_pt_a = 32'h4000;
    base_pt_b = 32'h20;
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      ctl("oor", 1'b0, 1'b0, t == 1, t == 1, t == 1);
      if (t == 1) chka("oor.addr", xbox_addr, 14'h3FFF);
      if (t == 2) chkw("oor.r1", r1_vec, {32{32'h10}});
      if (t == 2) chkw("oor.r2", r2_vec, {32{32'h20}});
      tick();
    end

    // Load and store together: load runs, err at T1 only, no write.
    base_pt_a = 32'h30;
    base_pt_b = 32'h40;
    base_pt_c = 32'h50;
    cmd_load = 1'b1;
    cmd_store = 1'b1;
    tick();
    cmd_load = 1'b0;
    cmd_store = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      ctl("dual", (t == 1) || (t == 4), 1'b0, t <= 7, t == 7, t == 1);
      if (t == 4) chka("dual.addr_b", xbox_addr, 14'h40);
      if (t == 7) chkw("dual.r1", r1_vec, {32{32'h30}});
      if (t == 7) chkw("dual.r2", r2_vec, {32{32'h40}});
      tick();
    end

    // Pointer change at T2 and re-issued load at T3 are both ignored.
    base_pt_a = 32'h11;
    base_pt_b = 32'h22;
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    done_cnt = 0;
    for (int t = 1; t <= 10; t++) begin
      if (done) done_cnt++;
      ctl("retrig", (t == 1) || (t == 4), 1'b0, t <= 7, t == 7, 1'b0);
      if (t == 1) chka("retrig.addr_a", xbox_addr, 14'h11);
      if (t == 4) chka("retrig.addr_b", xbox_addr, 14'h22);
      if (t == 7) chkw("retrig.r2", r2_vec, {32{32'h22}});
      if (t == 2) begin
        base_pt_a = 32'h77;
        base_pt_b = 32'h66;
      end
      cmd_load = (t == 3);
      tick();
    end
    cmd_load = 1'b0;
    chk1("retrig.one_done", done_cnt == 1, 1'b1);

    // Async reset at T5 of a load; the late response must not be captured.
    base_pt_a = 32'h12;
    base_pt_b = 32'h23;
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      ctl("pre_rst", (t == 1) || (t == 4), 1'b0, 1'b1, 1'b0, 1'b0);
      if (t < 5) tick();
    end
    rst_n = 1'b0;
    #1;
    rst_chk("async_rst");
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      ctl("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chkw("post_rst.r2", r2_vec, '0);
      tick();
    end

    // Fresh load after reset completes in 7 cycles.
    base_pt_a = 32'h13;
    base_pt_b = 32'h24;
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      ctl("reload", (t == 1) || (t == 4), 1'b0, t <= 7, t == 7, 1'b0);
      if (t == 4) chka("reload.addr_b", xbox_addr, 14'h24);
      if (t == 7) chkw("reload.r1", r1_vec, {32{32'h13}});
      if (t == 7) chkw("reload.r2", r2_vec, {32{32'h24}});
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
